// File: rtl/gfx_pkg.sv
// Shared graphics definitions: default screen geometry, coordinate widths,
// the line FSM state type and the packed line command layout.
package gfx_pkg;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;
  localparam int X_W_DEF      = 8;
  localparam int Y_W_DEF      = 7;
  localparam int LEN_W_DEF    = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2
  } line_state_t;

  // Command layout at the default coordinate geometry.
  typedef struct packed {
    logic        [X_W_DEF-1:0]   x0;
    logic        [Y_W_DEF-1:0]   y0;
    logic signed [LEN_W_DEF-1:0] dx;
    logic signed [LEN_W_DEF-1:0] dy;
  } line_cmd_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/line_raster_if.sv
// Command and pixel stream handshakes of the line rasteriser.
// master = command source / pixel sink, slave = rasteriser.
interface line_raster_if
  import gfx_pkg::*;
#(
  parameter int X_W   = X_W_DEF,
  parameter int Y_W   = Y_W_DEF,
  parameter int LEN_W = LEN_W_DEF
);

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic        [X_W-1:0]   cmd_x0;
  logic        [Y_W-1:0]   cmd_y0;
  logic signed [LEN_W-1:0] cmd_dx;
  logic signed [LEN_W-1:0] cmd_dy;

  logic                    px_valid;
  logic                    px_ready;
  logic        [X_W-1:0]   px_x;
  logic        [Y_W-1:0]   px_y;

  modport master (
    output cmd_valid, cmd_x0, cmd_y0, cmd_dx, cmd_dy, px_ready,
    input  cmd_ready, px_valid, px_x, px_y
  );

  modport slave (
    input  cmd_valid, cmd_x0, cmd_y0, cmd_dx, cmd_dy, px_ready,
    output cmd_ready, px_valid, px_x, px_y
  );

endinterface

// File: rtl/line_bres_step.sv
// One combinational Bresenham step: from the current error and position,
// produce the next error and position (x and y may both move).
module line_bres_step #(
  parameter int LEN_W = 9,
  parameter int POS_W = 11,
  parameter int ERR_W = LEN_W + 2
) (
  input  logic signed [ERR_W-1:0] err_i,
  input  logic        [LEN_W-1:0] adx_i,
  input  logic        [LEN_W-1:0] ady_i,
  input  logic signed [POS_W-1:0] cur_x_i,
  input  logic signed [POS_W-1:0] cur_y_i,
  input  logic                    sx_i,
  input  logic                    sy_i,
  output logic signed [ERR_W-1:0] err_o,
  output logic signed [POS_W-1:0] x_o,
  output logic signed [POS_W-1:0] y_o
);

  localparam int EW = ERR_W + 1;

  logic signed [EW-1:0] e2;
  logic signed [EW-1:0] adx_e;
  logic signed [EW-1:0] ady_e;
  logic signed [EW-1:0] err_sum;
  logic                 step_x;
  logic                 step_y;

  // One extra bit so that 2*err and -ady never overflow.
  always_comb begin
    e2      = $signed({err_i, 1'b0});
    adx_e   = $signed({{(EW-LEN_W){1'b0}}, adx_i});
    ady_e   = $signed({{(EW-LEN_W){1'b0}}, ady_i});
    step_x  = (e2 > -ady_e);
    step_y  = (e2 < adx_e);
    err_sum = {err_i[ERR_W-1], err_i};
    if (step_x) err_sum = err_sum - ady_e;
    if (step_y) err_sum = err_sum + adx_e;
  end

  assign err_o = err_sum[ERR_W-1:0];

  assign x_o = step_x ? (sx_i ? cur_x_i - POS_W'(1) : cur_x_i + POS_W'(1)) : cur_x_i;
  assign y_o = step_y ? (sy_i ? cur_y_i - POS_W'(1) : cur_y_i + POS_W'(1)) : cur_y_i;

endmodule

// File: rtl/line_raster.sv
// Bresenham line rasteriser: one command in, a clipped pixel stream out.
//   state | meaning
//   IDLE  | waiting for a command (cmd_ready high)
//   SETUP | derive |dx|, |dy|, step signs, initial error and length
//   DRAW  | emit or skip one point per step until the end point
module line_raster
  import gfx_pkg::*;
#(
  parameter int X_W      = X_W_DEF,
  parameter int Y_W      = Y_W_DEF,
  parameter int LEN_W    = LEN_W_DEF,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  line_raster_if.slave bus,
  output logic         busy,
  output logic         done
);

  // Positions are wide enough that any start plus any extent cannot wrap.
  localparam int POS_W = max_int(max_int(X_W, Y_W), LEN_W) + 2;
  localparam int ERR_W = LEN_W + 2;

  localparam logic signed [POS_W-1:0] SCR_W_P = POS_W'(SCREEN_W);
  localparam logic signed [POS_W-1:0] SCR_H_P = POS_W'(SCREEN_H);

  line_state_t              state_q, state_d;
  line_cmd_t                cmd_q, cmd_d;
  logic signed [ERR_W-1:0]  err_q, err_d;
  logic        [LEN_W-1:0]  adx_q, adx_d;
  logic        [LEN_W-1:0]  ady_q, ady_d;
  logic        [LEN_W-1:0]  rem_q, rem_d;
  logic                     sx_q, sx_d;
  logic                     sy_q, sy_d;
  logic signed [POS_W-1:0]  x_q, x_d;
  logic signed [POS_W-1:0]  y_q, y_d;

  logic signed [ERR_W-1:0]  err_step;
  logic signed [POS_W-1:0]  x_step;
  logic signed [POS_W-1:0]  y_step;
  logic signed [LEN_W-1:0]  dx_c;
  logic signed [LEN_W-1:0]  dy_c;
  logic                     on_screen;
  logic                     pv;
  logic                     advance;
  logic                     last;

  line_bres_step #(
    .LEN_W (LEN_W),
    .POS_W (POS_W),
    .ERR_W (ERR_W)
  ) u_step (
    .err_i   (err_q),
    .adx_i   (adx_q),
    .ady_i   (ady_q),
    .cur_x_i (x_q),
    .cur_y_i (y_q),
    .sx_i    (sx_q),
    .sy_i    (sy_q),
    .err_o   (err_step),
    .x_o     (x_step),
    .y_o     (y_step)
  );

  assign dx_c      = cmd_q.dx;
  assign dy_c      = cmd_q.dy;
  assign on_screen = !x_q[POS_W-1] && (x_q < SCR_W_P) &&
                     !y_q[POS_W-1] && (y_q < SCR_H_P);
  assign pv        = rst_n && (state_q == DRAW) && on_screen;
  // Off-screen points are skipped without waiting for the sink.
  assign advance   = (state_q == DRAW) && (on_screen ? bus.px_ready : 1'b1);
  assign last      = (rem_q == '0);

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    err_d   = err_q;
    adx_d   = adx_q;
    ady_d   = ady_q;
    rem_d   = rem_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    x_d     = x_q;
    y_d     = y_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          cmd_d.x0 = bus.cmd_x0;
          cmd_d.y0 = bus.cmd_y0;
          cmd_d.dx = bus.cmd_dx;
          cmd_d.dy = bus.cmd_dy;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        adx_d   = dx_c[LEN_W-1] ? (~dx_c + 1'b1) : dx_c;
        ady_d   = dy_c[LEN_W-1] ? (~dy_c + 1'b1) : dy_c;
        sx_d    = dx_c[LEN_W-1];
        sy_d    = dy_c[LEN_W-1];
        err_d   = $signed({2'b00, adx_d}) - $signed({2'b00, ady_d});
        rem_d   = (adx_d > ady_d) ? adx_d : ady_d;
        x_d     = POS_W'(cmd_q.x0);
        y_d     = POS_W'(cmd_q.y0);
        state_d = DRAW;
      end
      DRAW: begin
        if (advance) begin
          err_d = err_step;
          x_d   = x_step;
          y_d   = y_step;
          rem_d = rem_q - 1'b1;
          if (last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      err_q   <= '0;
      adx_q   <= '0;
      ady_q   <= '0;
      rem_q   <= '0;
      sx_q    <= 1'b0;
      sy_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      err_q   <= err_d;
      adx_q   <= adx_d;
      ady_q   <= ady_d;
      rem_q   <= rem_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign bus.cmd_ready = rst_n && (state_q == IDLE);
  assign bus.px_valid  = pv;
  assign bus.px_x      = pv ? x_q[X_W-1:0] : '0;
  assign bus.px_y      = pv ? y_q[Y_W-1:0] : '0;
  assign busy          = rst_n && (state_q != IDLE);
  assign done          = rst_n && advance && last;

endmodule
